except_commit: RTL and testbench

Commit-stage exception and ERTN handler for the two-wide retire path. It looks at the two oldest ROB entries presented each cycle and decides how many of them retire. It selects the oldest exception, interrupt or ERTN and raises one-cycle CSR update pulses. These pulses include the BADV write port `except_TLB_addr_en` / `except_TLB_addr_PC` that feeds the BADV register. It also issues the pipeline flush and front-end redirect, then holds off retirement while the flush drains.

---
 rtl/except_commit.sv | 256 +++++++++++++++++++++++++
 tb/tb_except_commit.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/except_commit.sv
// -----------------------------------------------------------------------------
// except_commit
//
// Commit-stage exception / interrupt / ERTN handler for the two-wide retire
// path. It looks at the two oldest ROB entries each cycle and decides how many
// of them retire. It picks the oldest event, which is an interrupt (slot 0
// only), an exception or an ERTN. From that event it raises one-cycle CSR
// update pulses, a pipeline flush and a front-end redirect. It then blocks
// retirement for FLUSH_CYCLES cycles while the flush drains.
//
// Ports:
//   clk, rst_n               core clock, asynchronous active-low reset
//   retire{0,1}_*            ROB head entries (slot 0 is older)
//   int_pending              enabled interrupt pending
//   EENTRY, TLBRENTRY, ERA   current CSR values
//   retire_ready             high while the block is in IDLE
//   commit{0,1}_en           combinational per-slot retire enables
//   flush, redirect_valid    one-cycle flush / redirect (registered)
//   redirect_pc              redirect target (registered, held)
//   except_TLB_addr_en/_PC   BADV write pulse / value
//   era_we, era_data         ERA write pulse / value
//   estat_we, estat_ecode,
//   estat_esubcode           ESTAT Ecode/EsubCode write pulse / values
//   crmd_except, crmd_ertn   CRMD save-and-enter-kernel / restore pulses
// -----------------------------------------------------------------------------
module except_commit #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        retire0_valid,
    input  logic        retire1_valid,
    input  logic [31:0] retire0_pc,
    input  logic [31:0] retire1_pc,
    input  logic        retire0_exc,
    input  logic        retire1_exc,
    input  logic [5:0]  retire0_ecode,
    input  logic [5:0]  retire1_ecode,
    input  logic [8:0]  retire0_esubcode,
    input  logic [8:0]  retire1_esubcode,
    input  logic [31:0] retire0_vaddr,
    input  logic [31:0] retire1_vaddr,
    input  logic        retire0_ertn,
    input  logic        retire1_ertn,
    input  logic        int_pending,
    input  logic [31:0] EENTRY,
    input  logic [31:0] TLBRENTRY,
    input  logic [31:0] ERA,
    output logic        retire_ready,
    output logic        commit0_en,
    output logic        commit1_en,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        except_TLB_addr_en,
    output logic [31:0] except_TLB_addr_PC,
    output logic        era_we,
    output logic [31:0] era_data,
    output logic        estat_we,
    output logic [5:0]  estat_ecode,
    output logic [8:0]  estat_esubcode,
    output logic        crmd_except,
    output logic        crmd_ertn
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam logic [5:0] ECODE_ADE  = 6'h08;
    localparam logic [5:0] ECODE_TLBR = 6'h3F;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;

    // Decoded event of the current cycle (valid only in IDLE)
    logic        ev;          // any event
    logic        ev_exc;      // exception or interrupt
    logic        ev_ertn;     // ERTN
    logic [5:0]  ev_ecode;
    logic [8:0]  ev_esubcode;
    logic [31:0] ev_pc;
    logic [31:0] ev_vaddr;
    logic        badv_en;
    logic [31:0] badv_val;
    logic [31:0] target_pc;

    // ------------------------------------------------------------------
    // Event selection and commit enables. Commits are suppressed while
    // reset is asserted so nothing retires before the block is running.
    // ------------------------------------------------------------------
    always_comb begin
        commit0_en  = 1'b0;
        commit1_en  = 1'b0;
        ev          = 1'b0;
        ev_exc      = 1'b0;
        ev_ertn     = 1'b0;
        ev_ecode    = 6'h00;
        ev_esubcode = 9'h000;
        ev_pc       = 32'h0;
        ev_vaddr    = 32'h0;
        if (rst_n && state_reg == IDLE && retire0_valid) begin
            if (int_pending) begin
                // Interrupts are only taken in front of the oldest entry
                ev     = 1'b1;
                ev_exc = 1'b1;
                ev_pc  = retire0_pc;
            end else if (retire0_exc) begin
                ev          = 1'b1;
                ev_exc      = 1'b1;
                ev_ecode    = retire0_ecode;
                ev_esubcode = retire0_esubcode;
                ev_pc       = retire0_pc;
                ev_vaddr    = retire0_vaddr;
            end else if (retire0_ertn) begin
                ev         = 1'b1;
                ev_ertn    = 1'b1;
                commit0_en = 1'b1;
            end else begin
                commit0_en = 1'b1;
                if (retire1_valid && retire1_exc) begin
                    ev          = 1'b1;
                    ev_exc      = 1'b1;
                    ev_ecode    = retire1_ecode;
                    ev_esubcode = retire1_esubcode;
                    ev_pc       = retire1_pc;
                    ev_vaddr    = retire1_vaddr;
                end else if (retire1_valid && retire1_ertn) begin
                    ev         = 1'b1;
                    ev_ertn    = 1'b1;
                    commit1_en = 1'b1;
                end else begin
                    commit1_en = retire1_valid;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // BADV source: fetch-side ADE reports the PC, the memory-side faults
    // report the data address. Interrupts and ERTN never write BADV.
    // ------------------------------------------------------------------
    always_comb begin
        badv_en  = 1'b0;
        badv_val = ev_vaddr;
        if (ev && ev_exc) begin
            case (ev_ecode)
                ECODE_ADE: begin
                    if (ev_esubcode == 9'd0) begin
                        badv_en  = 1'b1;
                        badv_val = ev_pc;
                    end else if (ev_esubcode == 9'd1) begin
                        badv_en = 1'b1;
                    end
                end
                6'h01, 6'h02, 6'h03, 6'h04, 6'h07, 6'h09, ECODE_TLBR: begin
                    badv_en = 1'b1;
                end
                default: badv_en = 1'b0;
            endcase
        end
    end

    always_comb begin
        if (ev_ertn) begin
            target_pc = ERA;
        end else if (ev_ecode == ECODE_TLBR) begin
            target_pc = TLBRENTRY;
        end else begin
            target_pc = EENTRY;
        end
    end

    // ------------------------------------------------------------------
    // FSM: IDLE -> DRAIN on any event. The counter is loaded with
    // FLUSH_CYCLES on entry and DRAIN exits the cycle after it reaches 1.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (ev) begin
                    state_next = DRAIN;
                    cnt_next   = 4'(FLUSH_CYCLES);
                end
            end
            DRAIN: begin
                if (cnt_reg <= 4'd1) begin
                    state_next = IDLE;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign retire_ready = (state_reg == IDLE);

    // ------------------------------------------------------------------
    // Registered pulses and held CSR write data. A data register updates
    // only together with its pulse, so it keeps the last written value.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush              <= 1'b0;
            redirect_valid     <= 1'b0;
            redirect_pc        <= 32'h0;
            except_TLB_addr_en <= 1'b0;
            except_TLB_addr_PC <= 32'h0;
            era_we             <= 1'b0;
            era_data           <= 32'h0;
            estat_we           <= 1'b0;
            estat_ecode        <= 6'h00;
            estat_esubcode     <= 9'h000;
            crmd_except        <= 1'b0;
            crmd_ertn          <= 1'b0;
        end else begin
            flush              <= ev;
            redirect_valid     <= ev;
            except_TLB_addr_en <= badv_en;
            era_we             <= ev && ev_exc;
            estat_we           <= ev && ev_exc;
            crmd_except        <= ev && ev_exc;
            crmd_ertn          <= ev && ev_ertn;
            if (ev) begin
                redirect_pc <= target_pc;
            end
            if (badv_en) begin
                except_TLB_addr_PC <= badv_val;
            end
            if (ev && ev_exc) begin
                era_data       <= ev_pc;
                estat_ecode    <= ev_ecode;
                estat_esubcode <= ev_esubcode;
            end
        end
    end

endmodule

// File: tb/tb_except_commit.sv
module tb_except_commit;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        v     [2];
    logic [31:0] pc    [2];
    logic        exc   [2];
    logic [5:0]  ec    [2];
    logic [8:0]  sc    [2];
    logic [31:0] va    [2];
    logic        ertn  [2];
    logic        intp;
    logic [31:0] eentry, tlbrentry, era;

    logic        retire_ready, commit0_en, commit1_en, flush, redirect_valid;
    logic [31:0] redirect_pc, except_TLB_addr_PC, era_data;
    logic        except_TLB_addr_en, era_we, estat_we, crmd_except, crmd_ertn;
    logic [5:0]  estat_ecode;
    logic [8:0]  estat_esubcode;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    except_commit #(.FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst_n(rst_n),
        .retire0_valid(v[0]), .retire1_valid(v[1]),
        .retire0_pc(pc[0]), .retire1_pc(pc[1]),
        .retire0_exc(exc[0]), .retire1_exc(exc[1]),
        .retire0_ecode(ec[0]), .retire1_ecode(ec[1]),
        .retire0_esubcode(sc[0]), .retire1_esubcode(sc[1]),
        .retire0_vaddr(va[0]), .retire1_vaddr(va[1]),
        .retire0_ertn(ertn[0]), .retire1_ertn(ertn[1]),
        .int_pending(intp),
        .EENTRY(eentry), .TLBRENTRY(tlbrentry), .ERA(era),
        .retire_ready(retire_ready),
        .commit0_en(commit0_en), .commit1_en(commit1_en),
        .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .except_TLB_addr_en(except_TLB_addr_en), .except_TLB_addr_PC(except_TLB_addr_PC),
        .era_we(era_we), .era_data(era_data),
        .estat_we(estat_we), .estat_ecode(estat_ecode), .estat_esubcode(estat_esubcode),
        .crmd_except(crmd_except), .crmd_ertn(crmd_ertn)
    );

    // ---------------- reference model ----------------
    typedef struct {
        bit        c0, c1, ev, exc, ertn, badv_en;
        bit [5:0]  ecode;
        bit [8:0]  sub;
        bit [31:0] era_v, badv, redir;
    } exp_t;

    // Held CSR-write data as last seen by the model
    bit [31:0] h_redir, h_era, h_badv;
    bit [5:0]  h_ecode;
    bit [8:0]  h_sub;

    function automatic bit badv_from_vaddr(input bit [5:0] e, input bit [8:0] s);
        bit [5:0] vlist [7] = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h07, 6'h09, 6'h3F};
        if (e == 6'h08) return (s == 9'd1);
        foreach (vlist[k]) if (vlist[k] == e) return 1'b1;
        return 1'b0;
    endfunction

    function automatic exp_t model();
        exp_t m;
        m = '{default: '0};
        if (!v[0]) return m;
        if (intp) begin
            m.ev = 1; m.exc = 1; m.era_v = pc[0];
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (!v[s]) break;
                if (exc[s]) begin
                    m.ev = 1; m.exc = 1; m.ecode = ec[s]; m.sub = sc[s]; m.era_v = pc[s];
                    if (ec[s] == 6'h08 && sc[s] == 9'd0) begin
                        m.badv_en = 1; m.badv = pc[s];
                    end else if (badv_from_vaddr(ec[s], sc[s])) begin
                        m.badv_en = 1; m.badv = va[s];
                    end
                    break;
                end
                if (s == 0) m.c0 = 1; else m.c1 = 1;
                if (ertn[s]) begin
                    m.ev = 1; m.ertn = 1;
                    break;
                end
            end
        end
        if (m.ertn) m.redir = era;
        else m.redir = (m.ecode == 6'h3F) ? tlbrentry : eentry;
        return m;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic clear_slots();
        for (int s = 0; s < 2; s++) begin
            v[s] = 0; pc[s] = 0; exc[s] = 0; ec[s] = 0; sc[s] = 0; va[s] = 0; ertn[s] = 0;
        end
        intp = 0;
    endtask

    task automatic randomize_inputs();
        bit [5:0] ecs [12] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h07,
                               6'h08, 6'h09, 6'h0B, 6'h3F, 6'h0C, 6'h1A};
        for (int s = 0; s < 2; s++) begin
            v[s]    = ($urandom_range(3) != 0);
            pc[s]   = $urandom;
            exc[s]  = ($urandom_range(3) == 0);
            ec[s]   = ecs[$urandom_range(11)];
            sc[s]   = 9'($urandom_range(2));
            va[s]   = $urandom;
            ertn[s] = ($urandom_range(7) == 0);
        end
        intp      = ($urandom_range(5) == 0);
        eentry    = $urandom;
        tlbrentry = $urandom;
        era       = $urandom;
    endtask

    task automatic settle_drain();
        clear_slots();
        repeat (FC + 1) @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear_slots();
        eentry = 32'h1C00_8000; tlbrentry = 32'h1C00_F000; era = 32'h0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({retire_ready, commit0_en, commit1_en, flush, redirect_valid, except_TLB_addr_en,
             era_we, estat_we, crmd_except, crmd_ertn} !== 10'b10_0000_0000) begin
            fails++; $display("FAIL reset_ctrl: got %b want 1000000000",
                {retire_ready, commit0_en, commit1_en, flush, redirect_valid, except_TLB_addr_en,
                 era_we, estat_we, crmd_except, crmd_ertn});
        end
        tests++;
        if ({redirect_pc, except_TLB_addr_PC, era_data, estat_ecode, estat_esubcode} !== '0) begin
            fails++; $display("FAIL reset_data: got %h %h %h %h %h want all 0",
                redirect_pc, except_TLB_addr_PC, era_data, estat_ecode, estat_esubcode);
        end
        rst_n = 1;
        @(posedge clk); #1;
        $display("[TB] reset done");
    endtask

    task automatic test_tlbr();
        clear_slots();
        v[0] = 1; exc[0] = 1; ec[0] = 6'h3F; pc[0] = 32'h1C00_0100; va[0] = 32'h00A0_0040;
        v[1] = 1; pc[1] = 32'h1C00_0104;
        #1;
        tests++;
        if ({commit0_en, commit1_en} !== 2'b00) begin
            fails++; $display("FAIL tlbr_commit: got %b want 00", {commit0_en, commit1_en});
        end
        @(posedge clk); #1;
        clear_slots();
        tests++;
        if ({except_TLB_addr_en, except_TLB_addr_PC, era_data, redirect_pc, flush}
            !== {1'b1, 32'h00A0_0040, 32'h1C00_0100, tlbrentry, 1'b1}) begin
            fails++; $display("FAIL tlbr_out: got en=%b badv=%h era=%h redir=%h flush=%b want 1 00a00040 1c000100 %h 1",
                except_TLB_addr_en, except_TLB_addr_PC, era_data, redirect_pc, flush, tlbrentry);
        end
        for (int i = 0; i <= FC; i++) begin
            tests++;
            if (retire_ready !== (i == FC)) begin
                fails++; $display("FAIL tlbr_ready[%0d]: got %b want %b", i, retire_ready, i == FC);
            end
            if (i < FC) begin
                @(posedge clk); #1;
            end
        end
        $display("[TB] tlbr event checked");
    endtask

    task automatic test_adef();
        clear_slots();
        v[0] = 1; exc[0] = 1; ec[0] = 6'h08; sc[0] = 9'd0; pc[0] = 32'h1C00_0003; va[0] = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        clear_slots();
        tests++;
        if ({except_TLB_addr_en, except_TLB_addr_PC, estat_ecode, estat_esubcode, redirect_pc}
            !== {1'b1, 32'h1C00_0003, 6'h08, 9'd0, eentry}) begin
            fails++; $display("FAIL adef: got en=%b badv=%h ec=%h sub=%h redir=%h want 1 1c000003 08 000 %h",
                except_TLB_addr_en, except_TLB_addr_PC, estat_ecode, estat_esubcode, redirect_pc, eentry);
        end
        settle_drain();
        $display("[TB] adef event checked");
    endtask

    task automatic test_slot1_ale();
        clear_slots();
        v[0] = 1; pc[0] = 32'h1C00_0200;
        v[1] = 1; pc[1] = 32'h1C00_0204; exc[1] = 1; ec[1] = 6'h09; va[1] = 32'h8000_0006;
        #1;
        tests++;
        if ({commit0_en, commit1_en} !== 2'b10) begin
            fails++; $display("FAIL ale_commit: got %b want 10", {commit0_en, commit1_en});
        end
        @(posedge clk); #1;
        clear_slots();
        tests++;
        if ({except_TLB_addr_en, except_TLB_addr_PC, era_data, estat_ecode, era_we}
            !== {1'b1, 32'h8000_0006, 32'h1C00_0204, 6'h09, 1'b1}) begin
            fails++; $display("FAIL ale_out: got en=%b badv=%h era=%h ec=%h we=%b want 1 80000006 1c000204 09 1",
                except_TLB_addr_en, except_TLB_addr_PC, era_data, estat_ecode, era_we);
        end
        settle_drain();
        $display("[TB] slot1 ALE checked");
    endtask

    task automatic test_slot1_ertn();
        clear_slots();
        era = 32'h1C00_2000;
        v[0] = 1; pc[0] = 32'h1C00_0300;
        v[1] = 1; pc[1] = 32'h1C00_0304; ertn[1] = 1;
        #1;
        tests++;
        if ({commit0_en, commit1_en} !== 2'b11) begin
            fails++; $display("FAIL ertn_commit: got %b want 11", {commit0_en, commit1_en});
        end
        @(posedge clk); #1;
        clear_slots();
        era = 32'h0;
        tests++;
        if ({crmd_ertn, redirect_pc, estat_we, era_we, except_TLB_addr_en, crmd_except, flush}
            !== {1'b1, 32'h1C00_2000, 5'b00001}) begin
            fails++; $display("FAIL ertn_out: got ertn=%b redir=%h estat_we=%b era_we=%b badv_en=%b crmd_exc=%b flush=%b want 1 1c002000 0 0 0 0 1",
                crmd_ertn, redirect_pc, estat_we, era_we, except_TLB_addr_en, crmd_except, flush);
        end
        settle_drain();
        $display("[TB] slot1 ERTN checked");
    endtask

    task automatic test_int_wins();
        clear_slots();
        intp = 1;
        v[0] = 1; exc[0] = 1; ec[0] = 6'h0B; pc[0] = 32'h1C00_0400;
        v[1] = 1; pc[1] = 32'h1C00_0404;
        #1;
        tests++;
        if ({commit0_en, commit1_en} !== 2'b00) begin
            fails++; $display("FAIL int_commit: got %b want 00", {commit0_en, commit1_en});
        end
        @(posedge clk); #1;
        clear_slots();
        tests++;
        if ({estat_we, estat_ecode, estat_esubcode, except_TLB_addr_en, era_data, crmd_except}
            !== {1'b1, 6'h00, 9'd0, 1'b0, 32'h1C00_0400, 1'b1}) begin
            fails++; $display("FAIL int_out: got we=%b ec=%h sub=%h badv_en=%b era=%h crmd=%b want 1 00 000 0 1c000400 1",
                estat_we, estat_ecode, estat_esubcode, except_TLB_addr_en, era_data, crmd_except);
        end
        settle_drain();
        $display("[TB] interrupt priority checked");
    endtask

    task automatic test_reset_mid_drain();
        clear_slots();
        v[0] = 1; exc[0] = 1; ec[0] = 6'h01; pc[0] = 32'h1C00_0500; va[0] = 32'h1234_5678;
        @(posedge clk); #1;
        // continuous clean valid traffic during the drain
        clear_slots();
        v[0] = 1; pc[0] = 32'h1C00_0600; v[1] = 1; pc[1] = 32'h1C00_0604;
        rst_n = 0;
        #1;
        tests++;
        if ({retire_ready, commit0_en, commit1_en, flush, redirect_valid, except_TLB_addr_en,
             era_we, estat_we, crmd_except, crmd_ertn} !== 10'b10_0000_0000) begin
            fails++; $display("FAIL rstdrain_ctrl: got %b want 1000000000",
                {retire_ready, commit0_en, commit1_en, flush, redirect_valid, except_TLB_addr_en,
                 era_we, estat_we, crmd_except, crmd_ertn});
        end
        tests++;
        if ({redirect_pc, except_TLB_addr_PC, era_data, estat_ecode, estat_esubcode} !== '0) begin
            fails++; $display("FAIL rstdrain_data: got %h %h %h %h %h want all 0",
                redirect_pc, except_TLB_addr_PC, era_data, estat_ecode, estat_esubcode);
        end
        rst_n = 1;
        #1;
        tests++;
        if ({retire_ready, commit0_en, commit1_en} !== 3'b111) begin
            fails++; $display("FAIL rstdrain_resume: got %b want 111", {retire_ready, commit0_en, commit1_en});
        end
        @(posedge clk); #1;
        clear_slots();
        $display("[TB] reset during drain checked");
    endtask

    task automatic test_back_to_back(input int n);
        exp_t m;
        // start from a known held-data state
        clear_slots();
        rst_n = 0; #2; rst_n = 1;
        h_redir = 0; h_era = 0; h_badv = 0; h_ecode = 0; h_sub = 0;
        for (int t = 0; t < n; t++) begin
            randomize_inputs();
            m = model();
            #1;
            tests++;
            if ({commit0_en, commit1_en} !== {m.c0, m.c1}) begin
                fails++; $display("FAIL b2b_commit[%0d]: got %b want %b", t, {commit0_en, commit1_en}, {m.c0, m.c1});
            end
            @(posedge clk); #1;
            if (m.ev) h_redir = m.redir;
            if (m.badv_en) h_badv = m.badv;
            if (m.exc) begin
                h_era = m.era_v; h_ecode = m.ecode; h_sub = m.sub;
            end
            tests++;
            if ({flush, redirect_valid, era_we, estat_we, crmd_except, crmd_ertn, except_TLB_addr_en, retire_ready}
                !== {m.ev, m.ev, m.exc, m.exc, m.exc, m.ertn, m.badv_en, !m.ev}) begin
                fails++; $display("FAIL b2b_pulses[%0d]: got %b want %b", t,
                    {flush, redirect_valid, era_we, estat_we, crmd_except, crmd_ertn, except_TLB_addr_en, retire_ready},
                    {m.ev, m.ev, m.exc, m.exc, m.exc, m.ertn, m.badv_en, !m.ev});
            end
            tests++;
            if ({redirect_pc, era_data, estat_ecode, estat_esubcode, except_TLB_addr_PC}
                !== {h_redir, h_era, h_ecode, h_sub, h_badv}) begin
                fails++; $display("FAIL b2b_data[%0d]: got %h %h %h %h %h want %h %h %h %h %h", t,
                    redirect_pc, era_data, estat_ecode, estat_esubcode, except_TLB_addr_PC,
                    h_redir, h_era, h_ecode, h_sub, h_badv);
            end
            $display("[TB] txn %0d ev=%0d exc=%0d ertn=%0d c=%0d%0d ecode=%h", t, m.ev, m.exc, m.ertn, m.c0, m.c1, m.ecode);
            if (m.ev) begin
                for (int i = 1; i <= FC; i++) begin
                    randomize_inputs();
                    #1;
                    tests++;
                    if ({commit0_en, commit1_en} !== 2'b00) begin
                        fails++; $display("FAIL b2b_drain_commit[%0d.%0d]: got %b want 00", t, i, {commit0_en, commit1_en});
                    end
                    @(posedge clk); #1;
                    tests++;
                    if ({retire_ready, flush, era_we, crmd_ertn, except_TLB_addr_en} !== {(i == FC), 4'b0000}) begin
                        fails++; $display("FAIL b2b_drain[%0d.%0d]: got %b want %b", t, i,
                            {retire_ready, flush, era_we, crmd_ertn, except_TLB_addr_en}, {(i == FC), 4'b0000});
                    end
                end
            end
        end
    endtask

    initial begin
        clear_slots();
        test_reset();
        test_tlbr();
        test_adef();
        test_slot1_ale();
        test_slot1_ertn();
        test_int_wins();
        test_reset_mid_drain();
        test_back_to_back(200);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
